// File: rtl/inv_rotate_ser.sv
// Byte-serial AES state collector with (Inv)ShiftRows permutation.
// Ports: in_* byte ingress (valid/ready, first), out_* 128-bit block (valid/ready),
// sync_err pulse on resync, blk_cnt delivered-block counter.
module inv_rotate_ser #(
  parameter bit INVERSE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  input  logic         in_first,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         sync_err,
  output logic [7:0]   blk_cnt
);

  logic [3:0]   idx_q, idx_d;
  logic [127:0] asm_q, asm_d;
  logic         asm_full_q, asm_full_d;
  logic         out_valid_q, out_valid_d;
  logic [127:0] out_data_q, out_data_d;
  logic         sync_err_q, sync_err_d;
  logic [7:0]   blk_cnt_q, blk_cnt_d;

  logic         accept;
  logic [3:0]   wr_idx;
  logic [6:0]   ofs;
  logic         complete;
  logic         out_free;
  logic         hs;
  logic         xfer;
  logic [127:0] blk_w;
  logic [127:0] perm;

  assign accept   = in_valid & ~asm_full_q;
  assign wr_idx   = in_first ? 4'd0 : idx_q;
  // byte i lives at [127-8i -: 8]; 15-i == ~i for 4 bits
  assign ofs      = {~wr_idx, 3'b000};
  assign complete = accept & ~in_first & (idx_q == 4'd15);
  assign hs       = out_valid_q & out_ready;
  assign out_free = ~out_valid_q | out_ready;
  assign xfer     = (asm_full_q | complete) & out_free;

  // Assembled block including the byte landing this cycle, so byte 15
  // can go straight to the output register in the same edge.
  always_comb begin
    blk_w = asm_q;
    if (accept) blk_w[ofs +: 8] = in_byte;
  end

  // state[r][c] = b[4c+r]; each output byte picks a source column
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      localparam int SC = INVERSE ? ((c - r + 4) % 4)
                                  : ((c + r) % 4);
      assign perm[127-8*(4*c+r) -: 8] =
        blk_w[127-8*(4*SC+r) -: 8];
    end
  end

  always_comb begin
    idx_d       = idx_q;
    asm_d       = blk_w;
    asm_full_d  = asm_full_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sync_err_d  = 1'b0;
    blk_cnt_d   = blk_cnt_q;
    if (accept) begin
      idx_d      = wr_idx + 4'd1;
      sync_err_d = in_first & (idx_q != 4'd0);
    end
    if (hs) begin
      out_valid_d = 1'b0;
      blk_cnt_d   = blk_cnt_q + 8'd1;
    end
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = perm;
      asm_full_d  = 1'b0;
    end else if (complete) begin
      asm_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      asm_q       <= '0;
      asm_full_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sync_err_q  <= 1'b0;
      blk_cnt_q   <= '0;
    end else begin
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      asm_full_q  <= asm_full_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sync_err_q  <= sync_err_d;
      blk_cnt_q   <= blk_cnt_d;
    end
  end

  assign in_ready  = ~asm_full_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sync_err  = sync_err_q;
  assign blk_cnt   = blk_cnt_q;

endmodule
